// File: rtl/code_word_serializer.sv
// ============================================================================
// code_word_serializer
// ----------------------------------------------------------------------------
// Parallel-to-serial readout for the code word held in the parallel hold
// register. A start request in IDLE latches the word, the bit count and the
// bit period, then shifts the word out MSB-first on a single serial line.
// Each bit is held for div+1 clocks. A frame-enable line (sdo_en), a busy
// flag, a one-cycle done pulse and a one-cycle len_err pulse are provided for
// the downstream pulse/transmit logic.
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous active-low reset
//   start    in   1      frame request, level-sampled, honoured only in IDLE
//   abort    in   1      synchronous frame cancel (effective in SHIFT only)
//   D        in   WIDTH  parallel code word from the hold register
//   len      in   LEN_W  number of bits to send from the MSB, 1..WIDTH
//   div      in   DIV_W  bit period minus one
//   sdo      out  1      serial data out
//   sdo_en   out  1      high while a bit is driven on sdo
//   busy     out  1      high from the first bit until the last bit ends
//   done     out  1      one-cycle pulse after a normal frame completion
//   len_err  out  1      one-cycle pulse when start is rejected for bad len
//
// All outputs come straight from flops; the next-cycle output values are
// computed alongside the next state so that the registered outputs line up
// with the state they describe.
// ============================================================================
module code_word_serializer #(
    parameter int WIDTH = 40,
    parameter int LEN_W = 6,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] D,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] div,
    output logic             sdo,
    output logic             sdo_en,
    output logic             busy,
    output logic             done,
    output logic             len_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [DIV_W-1:0] ONE_D   = DIV_W'(1);

    state_t             r_state;
    state_t             w_nextState;

    logic [WIDTH-1:0]   r_shiftReg;
    logic [LEN_W-1:0]   r_lenReg;
    logic [DIV_W-1:0]   r_divReg;
    logic [LEN_W-1:0]   r_bitCnt;
    logic [DIV_W-1:0]   r_perCnt;

    logic               r_sdo;
    logic               r_sdoEn;
    logic               r_busy;
    logic               r_done;
    logic               r_lenErr;

    logic               w_lenValid;
    logic               w_periodEnd;
    logic               w_lastBit;
    logic               w_load;
    logic               w_advance;
    logic               w_perInc;
    logic               w_sdoNext;
    logic               w_sdoEnNext;
    logic               w_busyNext;
    logic               w_doneNext;
    logic               w_lenErrNext;

    // A request is only legal for 1..WIDTH bits.
    assign w_lenValid  = (len != '0) && (len <= WIDTH_L);

    // Equality compare against the latched divider: the counter never has
    // to count past div, so even the maximum divider cannot wrap it.
    assign w_periodEnd = (r_perCnt == r_divReg);
    assign w_lastBit   = (r_bitCnt == (r_lenReg - ONE_L));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the values the output flops take next cycle.
    // Abort is checked before the end-of-frame test so a cancel that lands
    // on the final bit suppresses the done pulse.
    always_comb begin
        w_nextState  = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        w_perInc     = 1'b0;
        w_sdoNext    = 1'b0;
        w_sdoEnNext  = 1'b0;
        w_busyNext   = 1'b0;
        w_doneNext   = 1'b0;
        w_lenErrNext = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_lenValid) begin
                        w_nextState = SHIFT;
                        w_load      = 1'b1;
                        w_sdoNext   = D[WIDTH-1];
                        w_sdoEnNext = 1'b1;
                        w_busyNext  = 1'b1;
                    end else begin
                        w_lenErrNext = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    w_nextState = IDLE;
                end else if (w_periodEnd) begin
                    if (w_lastBit) begin
                        w_nextState = DONE;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_advance   = 1'b1;
                        w_sdoNext   = r_shiftReg[WIDTH-2];
                        w_sdoEnNext = 1'b1;
                        w_busyNext  = 1'b1;
                    end
                end else begin
                    w_perInc    = 1'b1;
                    w_sdoNext   = r_shiftReg[WIDTH-1];
                    w_sdoEnNext = 1'b1;
                    w_busyNext  = 1'b1;
                end
            end

            DONE: begin
                w_nextState = IDLE;
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Frame datapath: the word, length and divider are captured together on
    // acceptance so later changes on D, len or div cannot disturb a frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shiftReg <= '0;
            r_lenReg   <= '0;
            r_divReg   <= '0;
            r_bitCnt   <= '0;
            r_perCnt   <= '0;
        end else if (w_load) begin
            r_shiftReg <= D;
            r_lenReg   <= len;
            r_divReg   <= div;
            r_bitCnt   <= '0;
            r_perCnt   <= '0;
        end else if (w_advance) begin
            r_shiftReg <= {r_shiftReg[WIDTH-2:0], 1'b0};
            r_bitCnt   <= r_bitCnt + ONE_L;
            r_perCnt   <= '0;
        end else if (w_perInc) begin
            r_perCnt   <= r_perCnt + ONE_D;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sdo    <= 1'b0;
            r_sdoEn  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lenErr <= 1'b0;
        end else begin
            r_sdo    <= w_sdoNext;
            r_sdoEn  <= w_sdoEnNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
            r_lenErr <= w_lenErrNext;
        end
    end

    assign sdo     = r_sdo;
    assign sdo_en  = r_sdoEn;
    assign busy    = r_busy;
    assign done    = r_done;
    assign len_err = r_lenErr;

endmodule

// File: tb/tb_code_word_serializer.sv
// ============================================================================
// tb_code_word_serializer
// ----------------------------------------------------------------------------
// Directed bench for code_word_serializer. Inputs change on the falling edge,
// outputs are sampled on the falling edge, so "cycle k" is the k-th falling
// edge after the rising edge that sampled start.
// ============================================================================
module tb_code_word_serializer;

    localparam int WIDTH = 40;
    localparam int LEN_W = 6;
    localparam int DIV_W = 16;

    localparam logic [WIDTH-1:0] WORD_A = 40'h12EDED8000;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] D;
    logic [LEN_W-1:0] len;
    logic [DIV_W-1:0] div;
    logic             sdo;
    logic             sdo_en;
    logic             busy;
    logic             done;
    logic             len_err;

    int checks;
    int errors;

    code_word_serializer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .D       (D),
        .len     (len),
        .div     (div),
        .sdo     (sdo),
        .sdo_en  (sdo_en),
        .busy    (busy),
        .done    (done),
        .len_err (len_err)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a one-shot start request; returns just after the sampling edge.
    task automatic applyStart(input logic [WIDTH-1:0] d, input int l, input int dv);
        @(negedge clk);
        D     = d;
        len   = LEN_W'(l);
        div   = DIV_W'(dv);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Let a few idle cycles pass between scenarios.
    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [4:0] got;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        D     = '0;
        len   = '0;
        div   = '0;
        #1;
        got = {sdo, sdo_en, busy, done, len_err};
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b want=00000", got);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        got = {sdo, sdo_en, busy, done, len_err};
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_release_idle got=%b want=00000", got);
        end
    endtask

    // len=16, div=0: one bit per clock, done at cycle 17.
    task automatic test_basic;
        logic [3:0] got;
        logic [3:0] exp;
        logic [15:0] serial;
        applyStart(WORD_A, 16, 0);
        serial = '0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c <= 16) begin
                exp = {WORD_A[WIDTH-c], 3'b110};
                serial = {serial[14:0], sdo};
            end else if (c == 17) begin
                exp = 4'b0001;
            end else begin
                exp = 4'b0000;
            end
            got = {sdo, sdo_en, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL basic_cycle%0d got=%b want=%b", c, got, exp);
            end
        end
        checks++;
        if (serial !== 16'b0001001011101101) begin
            errors++;
            $display("[TB] FAIL basic_pattern got=%b want=0001001011101101", serial);
        end
    endtask

    // len=40, div=3: 160 busy cycles, each bit 4 clocks, one done pulse.
    task automatic test_long;
        logic [3:0] got;
        logic [3:0] exp;
        int bitIdx;
        int badCycles;
        int donePulses;
        logic [15:0] mid;
        logic [7:0] tail;
        applyStart(WORD_A, 40, 3);
        badCycles  = 0;
        donePulses = 0;
        mid  = '0;
        tail = '1;
        for (int c = 1; c <= 166; c++) begin
            @(negedge clk);
            if (done) donePulses++;
            if (c <= 160) begin
                bitIdx = (c - 1) / 4 + 1;
                exp = {WORD_A[WIDTH-bitIdx], 3'b110};
                if ((c - 1) % 4 == 0 && bitIdx >= 17 && bitIdx <= 32) mid = {mid[14:0], sdo};
                if ((c - 1) % 4 == 0 && bitIdx >= 33) tail = {tail[6:0], sdo};
            end else if (c == 161) begin
                exp = 4'b0001;
            end else begin
                exp = 4'b0000;
            end
            got = {sdo, sdo_en, busy, done};
            if (got !== exp) begin
                badCycles++;
                if (badCycles <= 4)
                    $display("[TB] FAIL long_cycle%0d got=%b want=%b", c, got, exp);
            end
        end
        checks++;
        if (badCycles !== 0) begin
            errors++;
            $display("[TB] FAIL long_frame bad_cycles=%0d want=0", badCycles);
        end
        checks++;
        if (mid !== 16'b1110110110000000) begin
            errors++;
            $display("[TB] FAIL long_bits17_32 got=%b want=1110110110000000", mid);
        end
        checks++;
        if (tail !== 8'h00) begin
            errors++;
            $display("[TB] FAIL long_bits33_40 got=%b want=00000000", tail);
        end
        checks++;
        if (donePulses !== 1) begin
            errors++;
            $display("[TB] FAIL long_done_count got=%0d want=1", donePulses);
        end
    endtask

    // len=0 and len=41 are rejected with a single len_err pulse.
    task automatic test_len_err;
        int badLens [2];
        logic [2:0] got;
        logic [2:0] exp;
        badLens[0] = 0;
        badLens[1] = 41;
        for (int t = 0; t < 2; t++) begin
            applyStart(WORD_A, badLens[t], 0);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                exp = (c == 1) ? 3'b100 : 3'b000;
                got = {len_err, busy, done};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("[TB] FAIL len_err_len%0d_cycle%0d got=%b want=%b",
                             badLens[t], c, got, exp);
                end
            end
        end
    endtask

    // len=16, div=1, abort in cycle 9; D and start disturbed mid-frame.
    task automatic test_abort;
        logic [3:0] got;
        logic [3:0] exp;
        int donePulses;
        applyStart(WORD_A, 16, 1);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            exp = {WORD_A[WIDTH-((c - 1) / 2 + 1)], 3'b110};
            got = {sdo, sdo_en, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL abort_pre_cycle%0d got=%b want=%b", c, got, exp);
            end
            if (c == 3) begin
                D     = '0;
                start = 1'b1;
            end
            if (c == 9) begin
                abort = 1'b1;
                start = 1'b0;
            end
        end
        donePulses = 0;
        for (int c = 10; c <= 15; c++) begin
            @(negedge clk);
            abort = 1'b0;
            if (done) donePulses++;
            if (c == 10) begin
                got = {sdo, sdo_en, busy, done};
                checks++;
                if (got !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL abort_cycle10 got=%b want=0000", got);
                end
            end
        end
        checks++;
        if (donePulses !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done got=%0d want=0", donePulses);
        end
    endtask

    // start+abort together in IDLE: start wins; abort on the last bit: no done.
    task automatic test_abort_last_bit;
        logic [3:0] got;
        @(negedge clk);
        D     = 40'h8000000000;
        len   = LEN_W'(1);
        div   = '0;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        got = {sdo, sdo_en, busy, done};
        checks++;
        if (got !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL start_beats_abort got=%b want=1110", got);
        end
        @(negedge clk);
        abort = 1'b0;
        got = {sdo, sdo_en, busy, done};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL abort_on_last_bit got=%b want=0000", got);
        end
        idleCycles(2);
    endtask

    // Asynchronous reset at cycle 5 of a len=16 frame.
    task automatic test_async_reset;
        logic [4:0] got;
        int activity;
        applyStart(WORD_A, 16, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL async_pre_busy got=%b want=1", busy);
        end
        #1 rst = 1'b0;
        #1;
        got = {sdo, sdo_en, busy, done, len_err};
        checks++;
        if (got !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL async_reset_immediate got=%b want=00000", got);
        end
        @(negedge clk);
        rst = 1'b1;
        activity = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy || done || sdo_en || sdo) activity++;
        end
        checks++;
        if (activity !== 0) begin
            errors++;
            $display("[TB] FAIL async_post_idle active_cycles=%0d want=0", activity);
        end
    endtask

    // start held high, len=2, div=0: 2 busy, 1 done, 1 idle, repeating.
    task automatic test_back_to_back;
        logic [WIDTH-1:0] word;
        logic [3:0] got;
        logic [3:0] exp;
        word = 40'hA000000000;
        @(negedge clk);
        D     = word;
        len   = LEN_W'(2);
        div   = '0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            case ((c - 1) % 4)
                0:       exp = {word[WIDTH-1], 3'b110};
                1:       exp = {word[WIDTH-2], 3'b110};
                2:       exp = 4'b0001;
                default: exp = 4'b0000;
            endcase
            got = {sdo, sdo_en, busy, done};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d got=%b want=%b", c, got, exp);
            end
        end
        start = 1'b0;
        idleCycles(3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        idleCycles(2);
        test_long();
        test_len_err();
        test_abort();
        idleCycles(2);
        test_abort_last_bit();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_word_serializer.md
Name: code_word_serializer

Overview:
- Parallel-to-serial readout for the 40-bit code word held in the parallel hold register.
- On a start request, latches the word and shifts it out MSB-first on a single-bit line.
- Each bit is held for a programmable number of clocks; a frame-enable line and a done pulse are provided for the downstream pulse/transmit logic.
- Sits between the code-word hold register and the transmitter front end.

Parameters:
- WIDTH, 40, code word width in bits; supported range 2..64.
- LEN_W, 6, width of the length input; must satisfy 2^LEN_W > WIDTH.
- DIV_W, 16, width of the bit-period divider input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a frame; level-sampled, honoured only in IDLE.
- abort  input  1  synchronous frame cancel.
- D  input  WIDTH  parallel code word, from the hold register output.
- len  input  LEN_W  number of bits to send, counted from MSB; valid range 1..WIDTH.
- div  input  DIV_W  bit period minus one: each bit lasts div+1 clocks.
- sdo  output  1  serial data out.
- sdo_en  output  1  high while a bit is being driven on sdo.
- busy  output  1  high from the first bit until the last bit ends.
- done  output  1  one-cycle pulse after a frame completes normally.
- len_err  output  1  one-cycle pulse when start is rejected for an invalid len.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; shift register, bit counter and period counter all cleared.
  - sdo=0, sdo_en=0, busy=0, done=0, len_err=0.
  - Reset asserted mid-frame kills the frame immediately; no done pulse follows.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - sdo=0 and sdo_en=0.
  - On an edge with start=1 and 1<=len<=WIDTH: latch D, len and div; go to SHIFT.
  - On an edge with start=1 and len=0 or len>WIDTH: stay in IDLE; len_err=1 for the next cycle only.
- SHIFT:
  - Entry: in the first SHIFT cycle, sdo=D[WIDTH-1] as latched, sdo_en=1, busy=1. Latency from the sampling edge to the first bit is one clock.
  - Each bit is held exactly div+1 cycles; the period counter counts 0..div.
  - At the end of each period, the shift register moves left by one and the bit counter increments.
  - After len bits, go to DONE. Total time in SHIFT is len*(div+1) cycles.
  - D, len and div changes during SHIFT have no effect, since all three were latched.
  - start during SHIFT is ignored and is not queued.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, sdo_en=0, sdo=0.
  - Then returns to IDLE. start is not accepted in this cycle.
- abort=1 in SHIFT: next cycle is IDLE with busy=0, sdo_en=0, sdo=0; no done pulse. abort in IDLE or DONE has no effect.
- Simultaneous abort and last-bit end: abort wins, no done pulse.
- Simultaneous start and abort in IDLE: start wins.
- div=0 gives one bit per clock. div at its maximum value must not overflow the period counter.
- Output timing: all outputs are registered, with no combinational path from any input to any output.

Test Plan:
- Reset, then D=40'h12EDED8000, len=16, div=0, start pulse -> sdo=0001001011101101 over cycles 1..16 after the sampling edge; sdo_en and busy high for exactly 16 cycles; done=1 at cycle 17.
- Same D, len=40, div=3 -> each bit held 4 cycles, 160 busy cycles; bits 17..32 read 1110110110000000 and bits 33..40 read 0; single done pulse.
- len=0, start -> len_err pulse for one cycle; busy stays 0, no done. Repeat with len=41 -> same response.
- Start with len=16, div=1; at cycle 9 assert abort for one cycle -> cycle 10 shows busy=0, sdo=0, no done. Drive D=0 and start=1 during the frame -> no effect on the serial output.
- rst=0 at cycle 5 of a len=16 frame -> all outputs 0 immediately, without waiting for a clock edge; after release the block idles until the next start.
- Back-to-back: hold start=1 continuously with len=2, div=0 -> pattern repeats as 2 busy cycles, 1 done cycle, 1 idle cycle.
